// File: rtl/ibuf_line_store_pkg.sv
// Shared widths, types and BIP field helpers for the instruction line buffer.
package ibuf_line_store_pkg;

    localparam int unsigned LINE_W    = 128;
    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned BIP_W     = 6;
    localparam int unsigned OFF_W     = 4;
    localparam int unsigned OCC_W     = 3;
    localparam int unsigned CNT_W     = 16;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [BIP_W-1:0]  bip_t;
    typedef logic [OFF_W-1:0]  off_t;

    // Slot index addressed by a byte instruction pointer.
    function automatic idx_t line_idx(input bip_t bip);
        return bip[BIP_W-1 -: IDX_W];
    endfunction

    // Byte offset within the addressed line.
    function automatic off_t byte_off(input bip_t bip);
        return bip[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/ibuf_line_store_if.sv
// Fetch_1 fill / fetch_2 consume interface of the line buffer.
// Optional starve_cnt signal present with IBUF_PERF_CNT_EN.
interface ibuf_line_store_if;
    import ibuf_line_store_pkg::*;

    logic     fill_valid;
    line_t    fill_data;
    logic     fill_ready;
    logic     advance;
    bip_t     old_BIP;
    bip_t     new_BIP;
    logic     flush;
    bip_t     flush_BIP;
    line_t    line_00;
    line_t    line_01;
    line_t    line_10;
    line_t    line_11;
    logic     line_00_valid;
    logic     line_01_valid;
    logic     line_10_valid;
    logic     line_11_valid;
    logic [OCC_W-1:0] occupancy;
`ifdef IBUF_PERF_CNT_EN
    logic [CNT_W-1:0] starve_cnt;

    modport master (
        output fill_valid, fill_data, advance, old_BIP, new_BIP, flush, flush_BIP,
        input  fill_ready, line_00, line_01, line_10, line_11,
               line_00_valid, line_01_valid, line_10_valid, line_11_valid,
               occupancy, starve_cnt
    );
    modport slave (
        input  fill_valid, fill_data, advance, old_BIP, new_BIP, flush, flush_BIP,
        output fill_ready, line_00, line_01, line_10, line_11,
               line_00_valid, line_01_valid, line_10_valid, line_11_valid,
               occupancy, starve_cnt
    );
`else
    modport master (
        output fill_valid, fill_data, advance, old_BIP, new_BIP, flush, flush_BIP,
        input  fill_ready, line_00, line_01, line_10, line_11,
               line_00_valid, line_01_valid, line_10_valid, line_11_valid,
               occupancy
    );
    modport slave (
        input  fill_valid, fill_data, advance, old_BIP, new_BIP, flush, flush_BIP,
        output fill_ready, line_00, line_01, line_10, line_11,
               line_00_valid, line_01_valid, line_10_valid, line_11_valid,
               occupancy
    );
`endif
endinterface

// File: rtl/ibuf_line_slot.sv
// One buffer slot: line data plus valid flag; clear/flush dominate set.
module ibuf_line_slot
    import ibuf_line_store_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  set_valid,
    input  logic  clr_valid,
    input  logic  flush,
    input  line_t din,
    output line_t dout,
    output logic  valid
);

    // Line data is only overwritten by a fill; release leaves it in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

    // Valid flag; a release or flush in the same cycle wins over a fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (flush || clr_valid) begin
            valid <= 1'b0;
        end else if (set_valid) begin
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ibuf_line_store.sv
// Four-slot, 16-byte-line instruction buffer feeding fetch_2's rotator.
// Optional perf counter starve_cnt enabled by IBUF_PERF_CNT_EN.
module ibuf_line_store
    import ibuf_line_store_pkg::*;
(
    input  logic clk,
    input  logic reset,
    ibuf_line_store_if.slave bus
);

    idx_t                 wr_ptr;
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] load;
    logic [NUM_LINES-1:0] clr;
    line_t                data [NUM_LINES];
    logic                 transfer;
    logic                 release_en;
    idx_t                 old_idx;
    logic [OCC_W-1:0]     occ;

    assign old_idx       = line_idx(bus.old_BIP);
    assign bus.fill_ready = ~valid[wr_ptr] & ~bus.flush;
    assign transfer      = bus.fill_valid & bus.fill_ready;
    assign release_en    = bus.advance & ~bus.flush &
                           (old_idx != line_idx(bus.new_BIP));

    // Decode fill target and released slot into per-slot strobes.
    always_comb begin
        load = '0;
        clr  = '0;
        load[wr_ptr]  = transfer;
        clr[old_idx]  = release_en;
    end

    // Slot storage.
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_slot
        ibuf_line_slot u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[g]),
            .set_valid (load[g]),
            .clr_valid (clr[g]),
            .flush     (bus.flush),
            .din       (bus.fill_data),
            .dout      (data[g]),
            .valid     (valid[g])
        );
    end

    // Write pointer: redirected by flush, otherwise steps on each accepted fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= line_idx(bus.flush_BIP);
        end else if (transfer) begin
            wr_ptr <= wr_ptr + idx_t'(1);
        end
    end

    // Popcount of valid slots.
    always_comb begin
        occ = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            occ = occ + OCC_W'(valid[i]);
        end
    end

    assign bus.occupancy     = occ;
    assign bus.line_00       = data[0];
    assign bus.line_01       = data[1];
    assign bus.line_10       = data[2];
    assign bus.line_11       = data[3];
    assign bus.line_00_valid = valid[0];
    assign bus.line_01_valid = valid[1];
    assign bus.line_10_valid = valid[2];
    assign bus.line_11_valid = valid[3];

`ifdef IBUF_PERF_CNT_EN
    idx_t             cur_idx;
    idx_t             nxt_idx;
    logic             starve;
    logic [CNT_W-1:0] starve_q;

    assign cur_idx = line_idx(bus.new_BIP);
    assign nxt_idx = cur_idx + idx_t'(1);
    assign starve  = ~bus.flush & ~(valid[cur_idx] & valid[nxt_idx]);

    // Saturating count of cycles in which fetch_2 cannot form a packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (starve && (starve_q != {CNT_W{1'b1}})) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end

    assign bus.starve_cnt = starve_q;
`endif

endmodule
